// File: rtl/crt_timing_pkg.sv
// Shared constants and decode helpers for crt_timing_gen; defaults are VGA 640x480@60.
package crt_timing_pkg;

  function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_start(int unsigned active, int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_end(int unsigned active, int unsigned fp,
                                           int unsigned sync);
    return active + fp + sync - 1;
  endfunction

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_CLK_DIV  = 4;

  localparam int unsigned VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int unsigned VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  localparam int unsigned VGA_HSYNC_START = sync_start(VGA_H_ACTIVE, VGA_H_FP);
  localparam int unsigned VGA_HSYNC_END   = sync_end(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);
  localparam int unsigned VGA_VSYNC_START = sync_start(VGA_V_ACTIVE, VGA_V_FP);
  localparam int unsigned VGA_VSYNC_END   = sync_end(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

endpackage

// File: rtl/crt_timing_gen_axis_counter.sv
// One timing axis: wrapping position counter plus decode of its next value.
module crt_axis_counter
  import crt_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_nxt,
  output logic          active_nxt
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(sync_start(ACTIVE, FP));
  localparam logic [CW-1:0] SYNC_LAST  = CW'(sync_end(ACTIVE, FP, SYNC));

  logic [CW-1:0] count_nxt;
  logic          terminal;

  assign terminal = (count == LAST);
  assign wrap     = advance & terminal;

  always_comb begin
    count_nxt = count;
    if (advance) begin
      count_nxt = terminal ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Decode looks at the next value so the registered outputs line up with count.
  assign sync_nxt   = ((count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST)) ? POL : ~POL;
  assign active_nxt = (count_nxt < CW'(ACTIVE));

endmodule

// File: rtl/crt_timing_gen.sv
// Parametrised CRT/VGA timing generator. Optional macro CRT_TIMING_PIPE_EN delays
// hsync/vsync/video_on by one pixel period to match a one-pixel-latency pixel pipeline.
module crt_timing_gen
  import crt_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = 10,
  parameter int unsigned FCW       = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  output logic           pixel_tick,
  output logic [CW-1:0]  xposition,
  output logic [CW-1:0]  yposition,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic          div_last;
  logic          h_wrap, v_wrap;
  logic          h_sync_nxt, v_sync_nxt;
  logic          h_active_nxt, v_active_nxt;
  logic          hsync_q, vsync_q, video_on_q;

  assign div_last = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      div        <= div_last ? '0 : div + DW'(1);
      pixel_tick <= div_last;
    end
  end

  crt_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk        (CLK),
    .rst_n      (RESET),
    .advance    (pixel_tick),
    .count      (xposition),
    .wrap       (h_wrap),
    .sync_nxt   (h_sync_nxt),
    .active_nxt (h_active_nxt)
  );

  crt_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk        (CLK),
    .rst_n      (RESET),
    .advance    (h_wrap),
    .count      (yposition),
    .wrap       (v_wrap),
    .sync_nxt   (v_sync_nxt),
    .active_nxt (v_active_nxt)
  );

  // v_wrap can only fire together with h_wrap, so it marks entry into (0,0).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      video_on_q  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hsync_q     <= h_sync_nxt;
      vsync_q     <= v_sync_nxt;
      video_on_q  <= h_active_nxt & v_active_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_count <= frame_count + FCW'(1);
      end
    end
  end

`ifdef CRT_TIMING_PIPE_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hsync    <= ~HSYNC_POL;
      vsync    <= ~VSYNC_POL;
      video_on <= 1'b1;
    end else if (pixel_tick) begin
      hsync    <= hsync_q;
      vsync    <= vsync_q;
      video_on <= video_on_q;
    end
  end
`else
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
`endif

endmodule

// File: tb/tb_crt_timing_gen.sv
// Randomised self-checking bench for crt_timing_gen: three configurations against a pixel-index model.
module tb_crt_timing_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct packed {
    int unsigned d;
    int unsigned ha, hf, hs, hb;
    int unsigned va, vf, vs, vb;
    int unsigned hpol, vpol, fcw;
  } cfg_t;

  localparam cfg_t CFG_A = '{d:4, ha:16, hf:2, hs:4, hb:3, va:6, vf:1, vs:2, vb:1,
                             hpol:0, vpol:0, fcw:3};
  localparam cfg_t CFG_B = '{d:1, ha:8, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1,
                             hpol:1, vpol:1, fcw:8};
  localparam cfg_t CFG_C = '{d:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                             hpol:0, vpol:0, fcw:8};

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  // Clock edges seen since reset was released; the model derives everything from this.
  int unsigned k;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) k <= 0;
    else        k <= k + 1;
  end

  logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [2:0] a_fc;
  logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;
  logic       c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [7:0] c_fc;

  crt_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(10), .FCW(3)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .pixel_tick(a_tick), .xposition(a_x), .yposition(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  crt_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(10), .FCW(8)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .pixel_tick(b_tick), .xposition(b_x), .yposition(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  crt_timing_gen dut_c (
    .CLK(CLK), .RESET(RESET), .pixel_tick(c_tick), .xposition(c_x), .yposition(c_y),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .line_start(c_ls),
    .frame_start(c_fs), .frame_count(c_fc)
  );

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_ls, a_fs, 5'b0, a_fc};
  assign obs_b = {b_tick, b_x, b_y, b_hs, b_vs, b_von, b_ls, b_fs, b_fc};
  assign obs_c = {c_tick, c_x, c_y, c_hs, c_vs, c_von, c_ls, c_fs, c_fc};

  int checks = 0;
  int errors = 0;

  // Pixel p has been reached after edge k when (k-1)/d ticks were consumed.
  function automatic obs_t model(int unsigned kk, cfg_t c);
    obs_t o;
    int unsigned ht, vt, p, q, line, qx, qy;
    logic moved;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    p = (kk == 0) ? 0 : (kk - 1) / c.d;
    line = p / ht;
    o.tick = (kk >= 1) && (kk % c.d == 0);
    o.x = 10'(p % ht);
    o.y = 10'(line % vt);
    o.fc = 8'((line / vt) % (32'd1 << c.fcw));
    moved = (kk >= 2) && ((kk - 1) % c.d == 0);
    o.ls = moved && (p % ht == 0);
    o.fs = o.ls && (line % vt == 0);
`ifdef CRT_TIMING_PIPE_EN
    q = (p == 0) ? 0 : p - 1;
`else
    q = p;
`endif
    qx = q % ht;
    qy = (q / ht) % vt;
    o.hs = (qx >= c.ha + c.hf && qx < c.ha + c.hf + c.hs) ? c.hpol[0] : ~c.hpol[0];
    o.vs = (qy >= c.va + c.vf && qy < c.va + c.vf + c.vs) ? c.vpol[0] : ~c.vpol[0];
    o.von = (qx < c.ha) && (qy < c.va);
    return o;
  endfunction

  task automatic test_reset();
    RESET = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      checks++;
      if ({obs_a, obs_b, obs_c} !== {model(0, CFG_A), model(0, CFG_B), model(0, CFG_C)}) begin
        errors++;
        $display("FAIL reset_state: got %h want %h", {obs_a, obs_b, obs_c},
                 {model(0, CFG_A), model(0, CFG_B), model(0, CFG_C)});
      end
    end
  endtask

  task automatic test_line_timing();
    int n = 0;
    int hs_low = 0;
    RESET = 1'b1;
    while (n < 20 && c_tick !== 1'b1) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL first_tick_latency: got %0d cycles want 4", n);
    end
    for (int i = 0; i < 3400; i++) begin
      if (c_hs === 1'b0) hs_low++;
      checks++;
      if ({obs_a, obs_b, obs_c} !== {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)}) begin
        errors++;
        $display("FAIL line_timing k=%0d: got %h want %h", k, {obs_a, obs_b, obs_c},
                 {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)});
      end
      @(negedge CLK);
    end
    checks++;
    if (hs_low != 384) begin
      errors++;
      $display("FAIL hsync_width: got %0d cycles want 384", hs_low);
    end
  endtask

  task automatic test_frames();
    logic saw_wrap = 1'b0;
    logic [7:0] prev_fc = b_fc;
    for (int i = 0; i < 19000; i++) begin
      @(negedge CLK);
      if (prev_fc == 8'd255 && b_fc == 8'd0) saw_wrap = 1'b1;
      prev_fc = b_fc;
      checks++;
      if ({obs_a, obs_b, obs_c} !== {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)}) begin
        errors++;
        $display("FAIL frame_timing k=%0d: got %h want %h", k, {obs_a, obs_b, obs_c},
                 {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)});
      end
    end
    checks++;
    if (saw_wrap !== 1'b1) begin
      errors++;
      $display("FAIL frame_count_wrap: got %b want 1", saw_wrap);
    end
  endtask

  task automatic test_async_reset();
    for (int it = 0; it < 5; it++) begin
      int unsigned run = $urandom_range(1500, 40);
      int unsigned hold = $urandom_range(5, 1);
      if (it == 4) begin
        int n = 0;
        while (n < 400 && a_hs !== 1'b0) begin
          @(negedge CLK);
          n++;
        end
        checks++;
        if (a_hs !== 1'b0) begin
          errors++;
          $display("FAIL wait_hsync: got %b want 0 within 400 cycles", a_hs);
        end
        run = 0;
      end
      for (int unsigned i = 0; i < run; i++) begin
        @(negedge CLK);
        checks++;
        if ({obs_a, obs_b, obs_c} !== {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)}) begin
          errors++;
          $display("FAIL pre_reset k=%0d: got %h want %h", k, {obs_a, obs_b, obs_c},
                   {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)});
        end
      end
      #2 RESET = 1'b0;
      #1;
      checks++;
      if ({obs_a, obs_b, obs_c} !== {model(0, CFG_A), model(0, CFG_B), model(0, CFG_C)}) begin
        errors++;
        $display("FAIL async_reset_immediate: got %h want %h", {obs_a, obs_b, obs_c},
                 {model(0, CFG_A), model(0, CFG_B), model(0, CFG_C)});
      end
      repeat (hold) @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge CLK);
        checks++;
        if ({obs_a, obs_b, obs_c} !== {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)}) begin
          errors++;
          $display("FAIL post_reset k=%0d: got %h want %h", k, {obs_a, obs_b, obs_c},
                   {model(k, CFG_A), model(k, CFG_B), model(k, CFG_C)});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frames();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
